// File: rtl/axil_cmd_seq.sv
// axil_cmd_seq: queued AXI4-Lite command sequencer (write, read, poll-until-match)
module axil_cmd_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int POLL_MAX    = 1024,
  parameter int POLL_GAP    = 8,
  parameter int STOP_ON_ERR = 1
) (
  input  logic                    M_AXI_aclk,
  input  logic                    M_AXI_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH-1:0]   cmd_mask,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [15:0]             rsp_polls,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    err_clr,
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [2:0]              M_AXI_awprot,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,
  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready,
  output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [2:0]              M_AXI_arprot,
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,
  input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rvalid,
  output logic                    M_AXI_rready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_POLL_GAP, S_FLUSH} state_t;
  state_t state, nxt;
  logic [1:0]            q_op   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_mask [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, cnt;
  logic full, empty, push, pop;
  logic [1:0] h_op, cur_op;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data, cur_mask, cmp_data;
  logic aw_pend, w_pend, aw_done, w_done, match, busy_q;
  logic cmp, cmp_to;
  logic [1:0] cmp_resp;
  logic [15:0] cmp_polls;
  logic [31:0] reads, gap;
  assign cnt       = wr_ptr - rd_ptr;
  assign full      = cnt == (AW+1)'(FIFO_DEPTH);
  assign empty     = cnt == '0;
  assign cmd_ready = !M_AXI_areset && !full && state != S_FLUSH;
  assign push      = cmd_valid && cmd_ready;
  assign h_op      = q_op[rd_ptr[AW-1:0]];
  assign busy      = !empty || state != S_IDLE;
  assign done      = busy_q && !busy;
  assign aw_done   = !aw_pend || M_AXI_awready;
  assign w_done    = !w_pend || M_AXI_wready;
  assign match     = ((M_AXI_rdata ^ cur_data) & cur_mask) == '0;
  assign M_AXI_awaddr  = cur_addr;
  assign M_AXI_awprot  = 3'b000;
  assign M_AXI_awvalid = aw_pend;
  assign M_AXI_wdata   = cur_data;
  assign M_AXI_wstrb   = '1;
  assign M_AXI_wvalid  = w_pend;
  assign M_AXI_bready  = state == S_WR_RESP;
  assign M_AXI_araddr  = cur_addr;
  assign M_AXI_arprot  = 3'b000;
  assign M_AXI_arvalid = state == S_RD_ADDR;
  assign M_AXI_rready  = state == S_RD_DATA;
  // queue storage, written on accepted pushes only
  always_ff @(posedge M_AXI_aclk) begin
    if (push) begin
      q_op[wr_ptr[AW-1:0]]   <= cmd_op;
      q_addr[wr_ptr[AW-1:0]] <= cmd_addr;
      q_data[wr_ptr[AW-1:0]] <= cmd_data;
      q_mask[wr_ptr[AW-1:0]] <= cmd_mask;
    end
  end
  // queue pointers; a flush drops everything still queued
  always_ff @(posedge M_AXI_aclk or posedge M_AXI_areset) begin
    if (M_AXI_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (state == S_FLUSH) rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // state register
  always_ff @(posedge M_AXI_aclk or posedge M_AXI_areset) begin
    if (M_AXI_areset) state <= S_IDLE;
    else state <= nxt;
  end
  // next state plus the completion event raised on the final handshake
  always_comb begin
    nxt       = state;
    pop       = 1'b0;
    cmp       = 1'b0;
    cmp_to    = 1'b0;
    cmp_resp  = 2'b00;
    cmp_data  = '0;
    cmp_polls = '0;
    case (state)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        cmp = h_op == 2'b11;
        nxt = h_op == 2'b00 ? S_WR_ADDR : h_op == 2'b11 ? S_IDLE : S_RD_ADDR;
      end
      S_WR_ADDR:  nxt = aw_done && w_done ? S_WR_RESP : S_WR_ADDR;
      S_WR_RESP: if (M_AXI_bvalid) begin
        cmp      = 1'b1;
        cmp_resp = M_AXI_bresp;
      end
      S_RD_ADDR:  nxt = M_AXI_arready ? S_RD_DATA : S_RD_ADDR;
      S_RD_DATA: if (M_AXI_rvalid) begin
        cmp_data  = M_AXI_rdata;
        cmp_resp  = M_AXI_rresp;
        cmp_polls = reads > 32'hFFFF ? 16'hFFFF : reads[15:0];
        cmp_to    = !(cur_op == 2'b01 || match || M_AXI_rresp[1]) && reads >= 32'(POLL_MAX);
        cmp       = cur_op == 2'b01 || match || M_AXI_rresp[1] || cmp_to;
        nxt       = POLL_GAP == 0 ? S_RD_ADDR : S_POLL_GAP;
      end
      S_POLL_GAP: nxt = gap == '0 ? S_RD_ADDR : S_POLL_GAP;
      S_FLUSH:    nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
    if (cmp) nxt = (cmp_resp[1] || cmp_to) && STOP_ON_ERR != 0 ? S_FLUSH : S_IDLE;
  end
  // current command, handshake tracking, poll counters, response and error flags
  always_ff @(posedge M_AXI_aclk or posedge M_AXI_areset) begin
    if (M_AXI_areset) begin
      cur_op      <= 2'b00;
      cur_addr    <= '0;
      cur_data    <= '0;
      cur_mask    <= '0;
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      reads       <= '0;
      gap         <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
      rsp_polls   <= '0;
      err         <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (pop) begin
        cur_op   <= h_op;
        cur_addr <= q_addr[rd_ptr[AW-1:0]];
        cur_data <= q_data[rd_ptr[AW-1:0]];
        cur_mask <= q_mask[rd_ptr[AW-1:0]];
        reads    <= '0;
      end else if (M_AXI_arvalid && M_AXI_arready) reads <= reads + 1'b1;
      aw_pend   <= (pop && h_op == 2'b00) || (aw_pend && !M_AXI_awready);
      w_pend    <= (pop && h_op == 2'b00) || (w_pend && !M_AXI_wready);
      gap       <= state == S_POLL_GAP ? gap - 32'd1 : 32'(POLL_GAP) - 32'd1;
      rsp_valid <= cmp;
      if (cmp) begin
        rsp_data    <= cmp_data;
        rsp_resp    <= cmp_resp;
        rsp_timeout <= cmp_to;
        rsp_polls   <= cmp_polls;
      end
      err    <= (cmp && (cmp_resp[1] || cmp_to)) || (err && !err_clr);
      busy_q <= busy;
    end
  end
endmodule

// File: tb/tb_axil_cmd_seq.sv
// tb_axil_cmd_seq: directed self-checking bench for axil_cmd_seq
module tb_axil_cmd_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [31:0] cmd_addr = 0, cmd_data = 0, cmd_mask = 0;
  logic rsp_valid, rsp_timeout, busy, done, err;
  logic err_clr = 0;
  logic [31:0] rsp_data;
  logic [1:0] rsp_resp;
  logic [15:0] rsp_polls;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0] bresp = 0, rresp = 0;
  logic [31:0] rdata = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  axil_cmd_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4), .POLL_MAX(4), .POLL_GAP(2), .STOP_ON_ERR(1)) dut (
    .M_AXI_aclk(clk), .M_AXI_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .rsp_polls(rsp_polls), .busy(busy), .done(done), .err(err), .err_clr(err_clr),
    .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
    .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
    .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
    .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    int t = 0;
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("push_wait", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic wr_slave(input int aw_dly, input int w_dly, input logic [1:0] br,
                          input logic [31:0] ea, input logic [31:0] ed, output int aw_hi, output int w_hi);
    int k = 0;
    bit aw_hs = 0, w_hs = 0, bad = 0;
    aw_hi = 0; w_hi = 0;
    while (!(awvalid || wvalid) && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (!(aw_hs && w_hs) && k < 50) begin
      if (awvalid) begin aw_hi++; if (awaddr !== ea || awprot !== 3'b000) bad = 1; end
      if (wvalid) begin w_hi++; if (wdata !== ed || wstrb !== 4'hf) bad = 1; end
      awready = awvalid && k >= aw_dly;
      wready  = wvalid && k >= w_dly;
      aw_hs |= awvalid && awready;
      w_hs  |= wvalid && wready;
      @(negedge clk); k++;
    end
    awready = 0; wready = 0;
    check("wr_payload", bad, 0);
    check("wr_valid_drop", {awvalid, wvalid}, 0);
    check("wr_bready", bready, 1);
    bvalid = 1; bresp = br;
    @(negedge clk);
    bvalid = 0; bresp = 0;
  endtask
  task automatic rd_slave(input logic [31:0] ea, input logic [31:0] rd, input logic [1:0] rr, output int idle);
    idle = 0;
    while (!arvalid && idle < 50) begin @(negedge clk); idle++; end
    check("ar_addr", {arprot, araddr}, {3'b000, ea});
    arready = 1;
    @(negedge clk);
    arready = 0;
    check("rd_rready", {arvalid, rready}, 2'b01);
    rvalid = 1; rdata = rd; rresp = rr;
    @(negedge clk);
    rvalid = 0; rdata = 0; rresp = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int awh, wh, idle;
    bit seen_aw, seen_ar, seen_done;
    repeat (3) @(negedge clk);
    check("rst_outputs", {cmd_ready, busy, done, err, rsp_valid, awvalid, wvalid, arvalid, bready, rready}, 0);
    rst = 0;
    #1 check("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    // single write with delayed awready
    push(2'b00, 32'h548, 32'h100, 32'h0);
    check("wr_busy", busy, 1);
    wr_slave(3, 0, 2'b00, 32'h548, 32'h100, awh, wh);
    check("wr_aw_cycles", awh, 4);
    check("wr_w_cycles", wh, 1);
    check("wr_rsp", {rsp_valid, rsp_resp, rsp_timeout}, {1'b1, 2'b00, 1'b0});
    check("wr_rsp_data", rsp_data, 0);
    check("wr_done", {done, busy}, 2'b10);
    @(negedge clk);
    check("wr_pulses_end", {done, rsp_valid}, 0);
    // single read
    push(2'b01, 32'h048, 32'h0, 32'h0);
    rd_slave(32'h048, 32'hDEADBEEF, 2'b00, idle);
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_data", rsp_data, 32'hDEADBEEF);
    check("rd_rsp_polls", rsp_polls, 1);
    check("rd_err", {err, rsp_resp, rsp_timeout}, 0);
    // poll matching on the third read
    push(2'b10, 32'h100, 32'h1, 32'h1);
    rd_slave(32'h100, 32'h0, 2'b00, idle);
    check("poll_no_rsp1", rsp_valid, 0);
    rd_slave(32'h100, 32'h0, 2'b00, idle);
    check("poll_gap1", idle >= 2, 1);
    rd_slave(32'h100, 32'h1, 2'b00, idle);
    check("poll_gap2", idle >= 2, 1);
    check("poll_rsp", {rsp_valid, rsp_timeout, rsp_resp}, {1'b1, 1'b0, 2'b00});
    check("poll_polls", rsp_polls, 3);
    check("poll_data", rsp_data, 1);
    seen_ar = 0;
    repeat (6) begin @(negedge clk); seen_ar |= arvalid; end
    check("poll_no_extra_ar", seen_ar, 0);
    // poll that never matches -> timeout after POLL_MAX reads
    push(2'b10, 32'h200, 32'h55, 32'hFF);
    for (int i = 0; i < 4; i++) rd_slave(32'h200, 32'h0, 2'b00, idle);
    check("to_rsp", {rsp_valid, rsp_timeout}, 2'b11);
    check("to_polls", rsp_polls, 4);
    check("to_err", err, 1);
    seen_ar = 0;
    repeat (8) begin @(negedge clk); seen_ar |= arvalid; end
    check("to_no_5th_read", seen_ar, 0);
    check("to_err_sticky", err, 1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    check("err_clr", err, 0);
    // three queued writes, SLVERR on the second flushes the third
    push(2'b00, 32'h10, 32'hA1, 32'h0);
    push(2'b00, 32'h20, 32'hA2, 32'h0);
    push(2'b00, 32'h30, 32'hA3, 32'h0);
    wr_slave(0, 0, 2'b00, 32'h10, 32'hA1, awh, wh);
    check("q1_rsp", {rsp_valid, rsp_resp, err}, {1'b1, 2'b00, 1'b0});
    wr_slave(1, 2, 2'b10, 32'h20, 32'hA2, awh, wh);
    check("q2_rsp", {rsp_valid, rsp_resp}, {1'b1, 2'b10});
    check("q2_err", err, 1);
    check("q2_flush_ready", cmd_ready, 0);
    seen_aw = 0; seen_done = 0;
    repeat (6) begin @(negedge clk); seen_aw |= awvalid; seen_done |= done; end
    check("q3_not_issued", seen_aw, 0);
    check("q_done_pulse", seen_done, 1);
    check("q_empty", {busy, cmd_ready}, 2'b01);
    // NOP completes immediately with OKAY
    push(2'b11, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("nop_rsp", {rsp_valid, rsp_resp, rsp_timeout}, {1'b1, 2'b00, 1'b0});
    check("nop_err_kept", err, 1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    // fill the queue while the write channel is stalled, then reset mid-write
    for (int i = 0; i < 5; i++) push(2'b00, 32'h400 + 32'(i), 32'(i), 32'h0);
    check("full_ready", cmd_ready, 0);
    check("full_aw_stalled", {awvalid, wvalid, busy}, 3'b111);
    #2 rst = 1;
    #1 check("rst_async", {awvalid, wvalid, busy, cmd_ready, rsp_valid, err, done}, 0);
    @(negedge clk);
    rst = 0;
    #1 check("rst_release_ready", cmd_ready, 1);
    seen_aw = 0;
    repeat (5) begin @(negedge clk); seen_aw |= awvalid || wvalid; end
    check("rst_queue_empty", {seen_aw, busy}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
